// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    localparam int unsigned RR_DEFAULT_PTR = 0;
    localparam int unsigned WD_W           = 16;

    // Index width for a requester count; never narrower than one bit.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request at or above ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = grant_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[(32'(ptr) + i) % N]) begin
                any    = 1'b1;
                winner = W'((32'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin arbiter sharing one uart_tx among NUM_REQ byte streams,
// with a watchdog that revokes a grant whose owner stalls mid-packet.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       timeout_err
);

    localparam int unsigned    GRANT_W  = grant_w(NUM_REQ);
    localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e         state;
    arb_state_e         state_next;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] pick_id;
    logic [GRANT_W-1:0] ptr_after;
    logic               pick_any;
    logic               last_q;
    logic [WD_W-1:0]    wd_cnt;
    logic [7:0]         grant_byte_c;
    logic               accept_c;
    logic               stall_c;
    logic               timeout_c;

    rr_pick #(
        .N (NUM_REQ),
        .W (GRANT_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (pick_id),
        .any    (pick_any)
    );

    // Pointer for the next arbitration: one past the releasing owner.
    assign ptr_after    = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + GRANT_W'(1);
    assign grant_byte_c = req_data[8*grant_id +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_any) state_next = LOAD;
            LOAD: begin
                if (accept_c) begin
                    state_next = HOLD;
                end else if (timeout_c) begin
                    state_next = IDLE;
                end
            end
            HOLD:    state_next = last_q ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Acceptance beats timeout: a stall cycle by definition has no valid byte.
    always_comb begin
        req_ready = '0;
        accept_c  = 1'b0;
        stall_c   = 1'b0;
        timeout_c = 1'b0;
        if (state == LOAD) begin
            accept_c            = req_valid[grant_id] & ~tx_busy;
            stall_c             = ~req_valid[grant_id] & ~tx_busy;
            timeout_c           = WD_EN && stall_c && (wd_cnt == WD_LIMIT);
            req_ready[grant_id] = accept_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id     <= '0;
            grant_active <= 1'b0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            timeout_err  <= 1'b0;
            rr_ptr       <= GRANT_W'(RR_DEFAULT_PTR);
            wd_cnt       <= '0;
            last_q       <= 1'b0;
        end else begin
            tx_start    <= accept_c;
            timeout_err <= timeout_c;
            unique case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (pick_any) begin
                        grant_id     <= pick_id;
                        grant_active <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        tx_data <= grant_byte_c;
                        last_q  <= req_last[grant_id];
                        wd_cnt  <= '0;
                    end else if (timeout_c) begin
                        grant_active <= 1'b0;
                        rr_ptr       <= ptr_after;
                        wd_cnt       <= '0;
                    end else if (stall_c && WD_EN) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                HOLD: begin
                    if (last_q) begin
                        grant_active <= 1'b0;
                        rr_ptr       <= ptr_after;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter among NUM_REQ byte-stream requesters (debug console, status reporter, register dump, etc.).
- Grants the transmitter per packet; arbitration is round-robin.
- Drives uart_tx's tx_data/tx_start pair and gates issue on tx_busy.
- Packets never interleave. A watchdog releases a grant held by a stalled requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 65535, mid-packet stall limit in clk cycles; 0 disables the watchdog (16-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks the final byte of a packet
req_ready  out  NUM_REQ  byte accepted this cycle (combinational)
grant_id  out  $clog2(NUM_REQ)  current owner; valid while grant_active
grant_active  out  1  a packet owner is held
tx_data  out  8  to uart_tx tx_data
tx_start  out  1  to uart_tx tx_start (registered, 1-cycle pulse)
tx_busy  in  1  from uart_tx tx_busy
timeout_err  out  1  1-cycle pulse when the watchdog revokes a grant

Behaviour:
- One clock. Reset is synchronous and active-high on rst. The top level ties uart_tx nrst = ~rst.
- Reset values:
  - state IDLE
  - grant_id 0, grant_active 0
  - tx_data 0x00, tx_start 0
  - timeout_err 0, req_ready all 0
  - rr pointer 0, watchdog counter 0
- States: IDLE, LOAD, HOLD.
- IDLE:
  - If |req_valid, pick the winner by round-robin: search from the rr pointer upward, wrapping.
  - Register grant_id = winner, grant_active=1, go to LOAD.
  - If no request, stay in IDLE.
- LOAD:
  - req_ready[grant_id] = req_valid[grant_id] & ~tx_busy. All other ready bits are 0.
  - On acceptance: tx_data <= req_data[grant_id], tx_start <= 1, clear the watchdog, go to HOLD.
  - Remember req_last of the accepted byte.
  - Watchdog increments only while req_valid[grant_id]=0 and tx_busy=0.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1:
    - pulse timeout_err, drop grant_active;
    - rr pointer <= grant_id+1 (mod NUM_REQ);
    - go to IDLE.
- HOLD:
  - Lasts exactly one cycle. tx_start is high during it, covering uart_tx's one-cycle tx_busy rise latency. tx_start returns to 0 next cycle.
  - If the remembered last=1: rr pointer <= grant_id+1 (mod NUM_REQ), grant_active <= 0, go to IDLE.
  - Otherwise go to LOAD.
- Latency:
  - Request in IDLE at cycle 0 → grant at cycle 1 → ready in cycle 1 if tx_busy=0 → tx_start high in cycle 2.
  - Back-to-back bytes within a packet: ready reasserts once tx_busy drops. uart_tx drops busy early, during the stop-bit shift, so serial output is continuous.
- tx_start is never asserted while tx_busy=1.
- The granted requester's data must be stable while valid=1 and ready=0.
- Simultaneous events:
  - req_last byte accepted in the same cycle another requester asserts valid: the other is arbitered in the next IDLE.
  - Timeout and acceptance in the same cycle: acceptance wins and the counter clears.
- Non-granted requesters' valid is ignored; they wait.
- Reset mid-operation:
  - Everything returns to reset values the next cycle.
  - A pending tx_start is cancelled.
  - The in-flight uart_tx frame is aborted by its own nrst.
- A single-byte packet has req_last=1 on its first byte.

Decomposition:
- Package uart_arb_pkg:
  - state enum arb_state_e {IDLE, LOAD, HOLD}
  - function clog2-based GRANT_W
  - constant RR_DEFAULT_PTR = 0
- Sub-module rr_pick:
  - combinational round-robin priority search.
  - inputs: req vector, pointer; outputs: winner index, any.

Test Plan:
1. NUM_REQ=4, req 2 sends 0xA5 with last=1, tx_busy from real uart_tx (BAUD_DIVISOR=4) → grant_id=2 cycle 1, tx_start pulse cycle 2, txd frame 0,1,0,1,0,0,1,0,1,1; return to IDLE.
2. Requesters 0 and 3 both request 3-byte packets {0x11,0x22,0x33} and {0xD1,0xD2,0xD3} in the same cycle → bytes 0x11,0x22,0x33 then 0xD1,0xD2,0xD3, no interleave; next simultaneous 0/3 request grants 0 first (pointer wrapped to 0 after grant 3).
3. All four requesters continuously requesting single-byte packets → grant order 0,1,2,3,0,...; tx_start never high while tx_busy=1.
4. TIMEOUT_CYCLES=16, req 1 sends 0x55 (last=0) then deasserts valid → timeout_err pulses once 16 idle cycles after acceptance; grant passes to pending req 2.
5. Assert rst during HOLD of req 0's multi-byte packet → next cycle tx_start=0, grant_active=0, req_ready=0; after release, fresh arbitration starts from pointer 0.
6. Hold tx_busy=1 externally for 50 cycles with req_valid[0]=1 → req_ready stays 0, watchdog does not count, no timeout_err; byte accepted the cycle after busy falls.
